// File: rtl/t02_control_scheduler.sv
// Control-loop scheduler: paces sense, setpoint, PID and servo strobes per loop tick.
// Optional periodic jerk windows are built when T02_JERK_INJECT_EN is defined.
module t02_control_scheduler #(
  parameter logic [15:0] LOOP_PERIOD   = 16'd10000,
  parameter logic [7:0]  STAGE_TIMEOUT = 8'd64,
  parameter logic [7:0]  JERK_PERIOD   = 8'd32,
  parameter logic [7:0]  JERK_DURATION = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       ball_detected,
  input  logic       sense_done,
  input  logic       pid_done,
  input  logic       clr_flags,
  output logic       sense_start,
  output logic       setpoint_en,
  output logic       pid_start,
  output logic       servo_en,
  output logic       jerk_active,
  output logic       overrun,
  output logic       timeout,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    SENSE     = 3'd2,
    SETPT     = 3'd3,
    PID       = 3'd4,
    SERVO     = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] timer;
  logic [7:0]  stage_cnt;
  logic        tick;
  logic        stage_to;
  logic        set_ovr;
  logic        set_to;

  assign state_out = state;

  always_comb begin
    tick     = (state != IDLE) && (timer == LOOP_PERIOD - 16'd1);
    stage_to = (stage_cnt == STAGE_TIMEOUT - 8'd1);
    // a tick outside WAIT_TICK is lost, not queued
    set_ovr  = run && tick && (state != WAIT_TICK);
    set_to   = run && stage_to &&
               (((state == SENSE) && !sense_done) ||
                ((state == PID) && !pid_done));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      stage_cnt   <= '0;
      sense_start <= 1'b0;
      setpoint_en <= 1'b0;
      pid_start   <= 1'b0;
      servo_en    <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      sense_start <= 1'b0;
      setpoint_en <= 1'b0;
      pid_start   <= 1'b0;
      servo_en    <= 1'b0;
      overrun     <= set_ovr | (overrun & ~clr_flags);
      timeout     <= set_to | (timeout & ~clr_flags);
      if (!run) begin
        state     <= IDLE;
        timer     <= '0;
        stage_cnt <= '0;
      end else begin
        timer     <= (state == IDLE || tick) ? '0 : timer + 16'd1;
        stage_cnt <= stage_cnt + 8'd1;
        case (state)
          IDLE: state <= WAIT_TICK;
          WAIT_TICK: begin
            if (tick) begin
              state       <= SENSE;
              sense_start <= 1'b1;
              stage_cnt   <= '0;
            end
          end
          SENSE: begin
            if (sense_done) begin
              state       <= SETPT;
              setpoint_en <= 1'b1;
            end else if (stage_to) begin
              state <= WAIT_TICK;
            end
          end
          SETPT: begin
            state     <= PID;
            pid_start <= 1'b1;
            stage_cnt <= '0;
          end
          PID: begin
            if (pid_done) begin
              state    <= SERVO;
              servo_en <= 1'b1;
            end else if (stage_to) begin
              state <= WAIT_TICK;
            end
          end
          SERVO:   state <= WAIT_TICK;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef T02_JERK_INJECT_EN
  logic [7:0] loop_cnt;
  logic [7:0] jerk_left;
  logic       jerk_q;
  logic       jerk_wrap;

  assign jerk_wrap   = (loop_cnt == JERK_PERIOD - 8'd1);
  assign jerk_active = jerk_q;

  // window length is counted in completed loops (SERVO cycles)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_cnt  <= '0;
      jerk_left <= '0;
      jerk_q    <= 1'b0;
    end else if (!run) begin
      loop_cnt  <= '0;
      jerk_left <= '0;
      jerk_q    <= 1'b0;
    end else if (state == SERVO) begin
      loop_cnt <= jerk_wrap ? 8'd0 : loop_cnt + 8'd1;
      if (jerk_wrap && ball_detected) begin
        jerk_q    <= (JERK_DURATION != 8'd0);
        jerk_left <= JERK_DURATION;
      end else if (jerk_q) begin
        jerk_left <= jerk_left - 8'd1;
        if (jerk_left == 8'd1) jerk_q <= 1'b0;
      end
    end
  end
`else
  logic jerk_unused;

  assign jerk_active = 1'b0;
  assign jerk_unused = ^{ball_detected, JERK_PERIOD, JERK_DURATION};
`endif

endmodule

// File: tb/tb_t02_control_scheduler.sv
// Bench for t02_control_scheduler: two configurations, cycle model plus directed checks.
// Jerk expectations follow T02_JERK_INJECT_EN.
module tb_t02_control_scheduler;

`ifdef T02_JERK_INJECT_EN
  localparam bit JERK_ON = 1'b1;
`else
  localparam bit JERK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       ball_detected;
  logic       clr_flags;
  logic       sd [2];
  logic       pd [2];
  logic       ss [2];
  logic       se [2];
  logic       ps [2];
  logic       sv [2];
  logic       ja [2];
  logic       ov [2];
  logic       to [2];
  logic [2:0] so [2];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  int sd_dly [2];
  int pd_dly [2];
  int scnt [2];
  int pcnt [2];
  int last_sv [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  t02_control_scheduler #(
    .LOOP_PERIOD(16'd20), .STAGE_TIMEOUT(8'd8),
    .JERK_PERIOD(8'd3), .JERK_DURATION(8'd2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .run(run),
    .ball_detected(ball_detected),
    .sense_done(sd[0]), .pid_done(pd[0]),
    .clr_flags(clr_flags),
    .sense_start(ss[0]), .setpoint_en(se[0]),
    .pid_start(ps[0]), .servo_en(sv[0]),
    .jerk_active(ja[0]), .overrun(ov[0]),
    .timeout(to[0]), .state_out(so[0])
  );

  t02_control_scheduler #(
    .LOOP_PERIOD(16'd10), .STAGE_TIMEOUT(8'd16),
    .JERK_PERIOD(8'd3), .JERK_DURATION(8'd2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .run(run),
    .ball_detected(ball_detected),
    .sense_done(sd[1]), .pid_done(pd[1]),
    .clr_flags(clr_flags),
    .sense_start(ss[1]), .setpoint_en(se[1]),
    .pid_start(ps[1]), .servo_en(sv[1]),
    .jerk_active(ja[1]), .overrun(ov[1]),
    .timeout(to[1]), .state_out(so[1])
  );

  function automatic int lp(int i);
    return (i == 0) ? 20 : 10;
  endfunction

  function automatic int tmo(int i);
    return (i == 0) ? 8 : 16;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // sensor/PID responders: done pulses a fixed number of cycles after the start strobe
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ss[i]) scnt[i] = 0;
      else if (scnt[i] < 1000) scnt[i]++;
      if (ps[i]) pcnt[i] = 0;
      else if (pcnt[i] < 1000) pcnt[i]++;
      sd[i] = (scnt[i] == sd_dly[i]);
      pd[i] = (pcnt[i] == pd_dly[i]);
      if (sv[i]) last_sv[i] = cyc;
    end
  end

  // model: phase (0 idle,1 wait,2 sense,3 setpt,4 pid,5 servo), cycles since loop tick, cycles in stage
  int m_ph [2];
  int m_tm [2];
  int m_age [2];
  int m_loops [2];
  int m_win [2];
  bit m_ov [2];
  bit m_to [2];

  always @(posedge clk or negedge rst_n) begin
    int oph, oage;
    bit tk, sov, sto, wrapped;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_ph[i] = 0; m_tm[i] = 0; m_age[i] = 0;
        m_loops[i] = 0; m_win[i] = 0;
        m_ov[i] = 0; m_to[i] = 0;
      end else begin
        oph = m_ph[i];
        oage = m_age[i];
        sov = 0;
        sto = 0;
        if (!run) begin
          m_ph[i] = 0; m_tm[i] = 0; m_age[i] = 0;
          m_loops[i] = 0; m_win[i] = 0;
        end else begin
          tk = (oph != 0) && (m_tm[i] == lp(i) - 1);
          sov = tk && (oph != 1);
          m_tm[i] = (oph == 0 || tk) ? 0 : m_tm[i] + 1;
          m_age[i] = oage + 1;
          if (oph == 0) m_ph[i] = 1;
          else if (oph == 1) begin
            if (tk) begin m_ph[i] = 2; m_age[i] = 0; end
          end else if (oph == 2 || oph == 4) begin
            if ((oph == 2) ? sd[i] : pd[i]) m_ph[i] = oph + 1;
            else if (oage + 1 >= tmo(i)) begin
              sto = 1;
              m_ph[i] = 1;
            end
          end else if (oph == 3) begin
            m_ph[i] = 4; m_age[i] = 0;
          end else begin
            m_ph[i] = 1;
            m_loops[i] = (m_loops[i] + 1) % 3;
            wrapped = (m_loops[i] == 0);
            if (wrapped && ball_detected) m_win[i] = 2;
            else if (m_win[i] > 0) m_win[i]--;
          end
        end
        m_ov[i] = sov | (m_ov[i] & !clr_flags);
        m_to[i] = sto | (m_to[i] & !clr_flags);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("state_out[%0d]", i), so[i], m_ph[i]);
        chk($sformatf("sense_start[%0d]", i), ss[i],
            int'(m_ph[i] == 2 && m_age[i] == 0));
        chk($sformatf("setpoint_en[%0d]", i), se[i], int'(m_ph[i] == 3));
        chk($sformatf("pid_start[%0d]", i), ps[i],
            int'(m_ph[i] == 4 && m_age[i] == 0));
        chk($sformatf("servo_en[%0d]", i), sv[i], int'(m_ph[i] == 5));
        chk($sformatf("overrun[%0d]", i), ov[i], m_ov[i]);
        chk($sformatf("timeout[%0d]", i), to[i], m_to[i]);
        chk($sformatf("jerk_active[%0d]", i), ja[i],
            int'(JERK_ON && m_win[i] > 0));
      end
    end
  end

  function automatic bit sig(int w, int i);
    case (w)
      0: return ss[i];
      1: return se[i];
      2: return ps[i];
      3: return sv[i];
      4: return ov[i];
      default: return to[i];
    endcase
  endfunction

  task automatic wait_for(input int w, input int i, input int lim,
                          input string nm, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (sig(w, i)) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errs++;
      $display("FAIL wait_%s: no event within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_edge, a1, a2, b1, t, p, c, c2, s;
    rst_n = 1'b0;
    run = 1'b0;
    ball_detected = 1'b1;
    clr_flags = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sd[i] = 1'b0; pd[i] = 1'b0;
      sd_dly[i] = 3; pd_dly[i] = 2;
      scnt[i] = 1000; pcnt[i] = 1000;
      last_sv[i] = -1;
    end
    repeat (2) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_state_a", so[0], 0);
    chk("rst_state_b", so[1], 0);
    chk("rst_sense_start", ss[0], 0);
    chk("rst_overrun", ov[0], 0);
    chk("rst_timeout", to[1], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_run", so[0], 0);

    // nominal loops: sense 3 late, pid 2 late
    run = 1'b1;
    run_edge = cyc + 1;
    wait_for(0, 1, 30, "ss_b", b1);
    chk("first_ss_b_delay", b1 - run_edge, 10);
    wait_for(0, 0, 30, "ss_a", a1);
    chk("first_ss_a_delay", a1 - run_edge, 20);
    wait_for(1, 0, 30, "se_a", t);
    chk("setpoint_offset", t - a1, 4);
    wait_for(2, 0, 30, "ps_a", t);
    chk("pid_start_offset", t - a1, 5);
    wait_for(3, 0, 30, "sv_a", t);
    chk("servo_offset", t - a1, 8);
    wait_for(0, 0, 30, "ss_a2", a2);
    chk("ss_spacing_a", a2 - a1, 20);
    chk("no_overrun_a", ov[0], 0);

    // PID never completes on u_a
    pd_dly[0] = -1;
    wait_for(2, 0, 30, "ps_a_to", p);
    wait_for(5, 0, 30, "timeout_a", t);
    chk("timeout_after_8", t - p, 8);
    chk("timeout_state", so[0], 1);
    chk("timeout_no_servo", int'(last_sv[0] < p), 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("timeout_cleared", to[0], 0);
    pd_dly[0] = 2;

    // u_b sensing 12 cycles late against a 10-cycle loop
    wait_for(0, 1, 30, "ss_b_ovr", c);
    sd_dly[1] = 12;
    repeat (9) @(negedge clk);
    chk("overrun_before", ov[1], 0);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("overrun_set_beats_clr", ov[1], 1);
    wait_for(0, 1, 30, "ss_b_next", c2);
    chk("ss_after_drop", c2 - c, 20);
    sd_dly[1] = 3;
    repeat (3) @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("overrun_cleared", ov[1], 0);

    // run dropped during PID
    wait_for(2, 0, 40, "ps_a_run", p);
    run = 1'b0;
    @(negedge clk);
    chk("run0_idle", so[0], 0);
    repeat (2) @(negedge clk);
    chk("run0_no_servo", sv[0], 0);
    run = 1'b1;
    run_edge = cyc + 1;
    wait_for(0, 0, 40, "ss_a_rerun", s);
    chk("rerun_delay", s - run_edge, 20);
    chk("rerun_no_servo", int'(last_sv[0] < p), 1);

    // asynchronous reset while sensing
    wait_for(0, 0, 40, "ss_a_rst", s);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", so[0], 0);
    chk("async_rst_ss", ss[0], 0);
    chk("async_rst_se", se[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", so[0], 1);
    chk("post_rst_ss", ss[0], 0);

    // jerk window after the 3rd servo, none when ball absent
    for (int k = 0; k < 3; k++) wait_for(3, 0, 40, "sv_jerk", t);
    @(negedge clk);
    chk("jerk_after_3rd_servo", ja[0], int'(JERK_ON));
    ball_detected = 1'b0;
    for (int k = 0; k < 3; k++) wait_for(3, 0, 40, "sv_nojerk", t);
    @(negedge clk);
    chk("jerk_no_ball", ja[0], 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
